unary_window_decoder: RTL
=========================

UNARY_WINDOW_DECODER -- requirements
Module: unary_window_decoder

Interface
REQ-001 Parameter WIN, default 16, sets the number of unary bits per window (legal 2..64).
REQ-002 Parameter CW, default 5, sets the count width and SHALL equal $clog2(WIN+1).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 bit_in  input  1  serial unary bit (comparator "gt" output of the upstream unary generator).
REQ-006 bit_valid  input  1  bit_in is meaningful this cycle.
REQ-007 frame_start  input  1  marks the first bit of a window; qualified by bit_valid.
REQ-008 count_out  output  CW  number of ones in the last completed window.
REQ-009 out_valid  output  1  count_out holds a completed result.
REQ-010 out_ready  input  1  downstream accepts count_out.
REQ-011 overrun  output  1  sticky: a window start was dropped while a result was pending.
REQ-012 mono_err  output  1  result carries a non-thermometer-code error (see Configuration).

Function
REQ-013 Three states: IDLE, COLLECT, HOLD.
REQ-014 IDLE: bit_valid&frame_start -> COLLECT; ones=bit_in, pos=1; other input is ignored.
REQ-015 COLLECT, each bit_valid cycle: ones+=bit_in, pos+=1; cycles without bit_valid leave state unchanged.
REQ-016 COLLECT, bit_valid&frame_start -> window restarts: partial count discarded, ones=bit_in, pos=1, no output.
REQ-017 When the WIN-th bit is accepted in cycle N, count_out=final ones and out_valid=1 from cycle N+1; state -> HOLD.
REQ-018 Latency is exactly one cycle from the last accepted bit to out_valid.
REQ-019 HOLD: count_out and mono_err stable until out_valid&out_ready.
REQ-020 HOLD with handshake: out_valid drops the next cycle; state -> IDLE, unless bit_valid&frame_start in the same cycle, in which case -> COLLECT with that bit as the first bit.
REQ-021 HOLD without handshake: bit_valid&frame_start sets overrun=1 and the bit is dropped; other bits are dropped silently.
REQ-022 Counter arithmetic never wraps: ones<=WIN always; an all-ones window yields count_out=WIN (16 = 5'b10000).
REQ-023 out_ready while out_valid=0 has no effect.

Reset
REQ-024 rst_n=0 at a clock edge -> state IDLE; ones=0; pos=0; count_out=0; out_valid=0; overrun=0; mono_err=0.
REQ-025 Reset during COLLECT or HOLD discards partial and pending results; no out_valid is produced for them.
REQ-026 overrun clears only on reset.

Configuration
REQ-027 Macro UNARY_MONO_CHECK_EN.
REQ-028 Defined: a window is flagged if bit_in=1 arrives after any bit_in=0 in the same window (not a ones-then-zeros thermometer code); mono_err is presented with count_out, and has the same validity and stability as count_out.
REQ-029 Not defined: mono_err is tied to 0 and the check logic is absent; all other behaviour is identical.

Verification
REQ-030 WIN=16; frame_start, then bits 1x5 then 0x11; out_ready=1 -> count_out=5 and out_valid for exactly 1 cycle, one cycle after the 16th bit; mono_err=0.
REQ-031 16 ones; out_ready=0 for 4 cycles, then 1 -> count_out=16 held for all 5 cycles; out_valid drops after the handshake.
REQ-032 frame_start again after 7 bits (3 ones), then a full window of 9 ones / 7 zeros -> a single result, count_out=9.
REQ-033 Result pending with out_ready=0, new frame_start -> overrun=1 and stays 1; after the handshake the next window decodes normally.
REQ-034 Handshake and frame_start in the same cycle, followed by 15 more bits (4 ones in total) -> count_out=4 with no lost window; bit_valid gaps inserted mid-window do not change the count.
REQ-035 With UNARY_MONO_CHECK_EN, pattern 1,1,0,1 then zeros -> count_out=3, mono_err=1; rst_n=0 mid-window -> all outputs 0 and no result.

Source files
------------

// File: rtl/unary_window_decoder_if.sv
// Handshake bundle between a unary bit source, the window decoder and the count consumer.
// The master drives bits and out_ready; the slave (decoder) returns the count and status.
interface unary_window_decoder_if #(
    parameter int CW = 5
);
    logic          bit_in;
    logic          bit_valid;
    logic          frame_start;
    logic          out_ready;
    logic [CW-1:0] count_out;
    logic          out_valid;
    logic          overrun;
    logic          mono_err;

    modport master (
        output bit_in, bit_valid, frame_start, out_ready,
        input  count_out, out_valid, overrun, mono_err
    );

    modport slave (
        input  bit_in, bit_valid, frame_start, out_ready,
        output count_out, out_valid, overrun, mono_err
    );
endinterface

// File: rtl/unary_window_decoder.sv
// Counts the ones in each WIN-bit unary window and hands the count downstream with valid/ready.
// Optional thermometer-code check enabled by defining UNARY_MONO_CHECK_EN.
module unary_window_decoder #(
    parameter int WIN = 16,
    parameter int CW  = 5
) (
    input logic               clk,
    input logic               rst_n,
    unary_window_decoder_if.slave win
);

    if (CW != $clog2(WIN + 1) || WIN < 2 || WIN > 64) begin : g_param_check
        $error("unary_window_decoder: WIN must be 2..64 and CW must equal $clog2(WIN+1)");
    end

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] ones;
    logic [CW-1:0] pos;
    logic [CW-1:0] count_r;
    logic          out_valid_r;
    logic          overrun_r;

    logic          start;
    logic [CW-1:0] ones_next;
    logic [CW-1:0] pos_next;
    logic          last_bit;

    assign start     = win.bit_valid & win.frame_start;
    assign ones_next = ones + CW'(win.bit_in);
    assign pos_next  = pos + CW'(1);
    // pos never exceeds WIN, so ones (<= pos) fits CW bits without wrapping
    assign last_bit  = (pos_next == CW'(WIN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ones        <= '0;
            pos         <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ones  <= CW'(win.bit_in);
                        pos   <= CW'(1);
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (start) begin
                        ones <= CW'(win.bit_in);
                        pos  <= CW'(1);
                    end else if (win.bit_valid) begin
                        ones <= ones_next;
                        pos  <= pos_next;
                        if (last_bit) begin
                            count_r     <= ones_next;
                            out_valid_r <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // out_valid is always high here, so out_ready alone completes the handshake
                    if (win.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (start) begin
                            ones  <= CW'(win.bit_in);
                            pos   <= CW'(1);
                            state <= COLLECT;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (start) begin
                        overrun_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign win.count_out = count_r;
    assign win.out_valid = out_valid_r;
    assign win.overrun   = overrun_r;

`ifdef UNARY_MONO_CHECK_EN
    logic seen_zero;
    logic mono_acc;
    logic mono_r;
    logic load_first;
    logic accept_bit;
    logic mono_next;

    assign load_first = start & ((state != HOLD) | win.out_ready);
    assign accept_bit = win.bit_valid & ~win.frame_start & (state == COLLECT);
    // a one after any zero breaks the ones-then-zeros thermometer shape
    assign mono_next  = mono_acc | (win.bit_in & seen_zero);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_zero <= 1'b0;
            mono_acc  <= 1'b0;
            mono_r    <= 1'b0;
        end else if (load_first) begin
            seen_zero <= ~win.bit_in;
            mono_acc  <= 1'b0;
        end else if (accept_bit) begin
            seen_zero <= seen_zero | ~win.bit_in;
            mono_acc  <= mono_next;
            if (last_bit) begin
                mono_r <= mono_next;
            end
        end
    end

    assign win.mono_err = mono_r;
`else
    assign win.mono_err = 1'b0;
`endif

endmodule
